// File: rtl/simple_top_safety_pkg.sv
// Shared types and constants for the SIMPLE_TOP parity-error collector.
package simple_top_safety_pkg;

    localparam int unsigned DEFAULT_NUM_SRC = 4;

    localparam int unsigned SRC_WADDR = 0;
    localparam int unsigned SRC_WDATA = 1;
    localparam int unsigned SRC_RADDR = 2;
    localparam int unsigned SRC_RDATA = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPend    = 2'd1,
        StWaitClr = 2'd2
    } state_t;

endpackage

// File: rtl/simple_top_rail_chk.sv
// Dual-rail complementarity check for one source: two consecutive mismatch cycles latch a fault
// that only reset clears.
module simple_top_rail_chk (
    input  logic ACLK,
    input  logic RESET_ACLK,
    input  logic err,
    input  logic errb,
    output logic fault
);

    logic mism;
    logic mism_q;
    logic fault_q;

    assign mism = (err == errb);

    always_ff @(posedge ACLK or posedge RESET_ACLK) begin
        if (RESET_ACLK) begin
            mism_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            mism_q <= mism;
            if (mism && mism_q) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;

endmodule

// File: rtl/simple_top_err_collector.sv
// Collects dual-rail parity errors: edge-detected events, sticky status, saturating counter,
// interrupt with ack/clear handshake and a fatal rail-fault flag.
module simple_top_err_collector
    import simple_top_safety_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEFAULT_NUM_SRC,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               ACLK,
    input  logic               RESET_ACLK,
    input  logic [NUM_SRC-1:0] ERR_IN,
    input  logic [NUM_SRC-1:0] ERR_IN_B,
    input  logic [NUM_SRC-1:0] EN_SRC,
    input  logic               CLR_VALID,
    input  logic [NUM_SRC-1:0] CLR_MASK,
    input  logic               CLR_CNT,
    output logic               CLR_READY,
    output logic               IRQ,
    input  logic               IRQ_ACK,
    output logic [NUM_SRC-1:0] ERR_STICKY,
    output logic [CNT_W-1:0]   ERR_CNT,
    output logic [NUM_SRC-1:0] RAIL_FAULT,
    output logic               FATAL
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_SRC-1:0] err_q;
    logic [NUM_SRC-1:0] errb_q;
    logic [NUM_SRC-1:0] err_d;
    logic [NUM_SRC-1:0] ev;
    logic               any_ev;
    logic               clr_acc;
    logic [NUM_SRC-1:0] sticky_q;
    logic [NUM_SRC-1:0] sticky_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    state_t             state_q;

    assign ev      = err_q & ~err_d & EN_SRC;
    assign any_ev  = |ev;
    assign clr_acc = CLR_VALID & CLR_READY;

    // A new event wins over a clear of the same bit.
    always_comb begin
        sticky_nxt = sticky_q;
        if (clr_acc) begin
            sticky_nxt = sticky_q & ~CLR_MASK;
        end
        sticky_nxt = sticky_nxt | ev;
    end

    // Counter clear racing an event leaves exactly that one event counted.
    always_comb begin
        cnt_nxt = cnt_q;
        if (clr_acc && CLR_CNT) begin
            cnt_nxt = any_ev ? CNT_W'(1) : '0;
        end else if (any_ev && (cnt_q != CNT_MAX)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ACLK or posedge RESET_ACLK) begin
        if (RESET_ACLK) begin
            err_q    <= '0;
            errb_q   <= '0;
            err_d    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            err_q    <= ERR_IN;
            errb_q   <= ERR_IN_B;
            err_d    <= err_q;
            sticky_q <= sticky_nxt;
            cnt_q    <= cnt_nxt;
        end
    end

    always_ff @(posedge ACLK or posedge RESET_ACLK) begin
        if (RESET_ACLK) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|sticky_q) state_q <= StPend;
                end
                StPend: begin
                    if (IRQ_ACK) state_q <= StWaitClr;
                end
                StWaitClr: begin
                    if (any_ev) begin
                        state_q <= StPend;
                    end else if (sticky_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_rail
        simple_top_rail_chk u_rail_chk (
            .ACLK       (ACLK),
            .RESET_ACLK (RESET_ACLK),
            .err        (err_q[i]),
            .errb       (errb_q[i]),
            .fault      (RAIL_FAULT[i])
        );
    end

    assign IRQ        = (state_q == StPend);
    assign CLR_READY  = (state_q != StPend);
    assign ERR_STICKY = sticky_q;
    assign ERR_CNT    = cnt_q;
    assign FATAL      = |RAIL_FAULT;

endmodule
